// File: rtl/upc_tag_tx_pkg.sv
// Shared definitions for the item-tag serial link: frame layout, FSM states
// and the parity rule used by both the checkout transmitter and the gate decoder.
package upc_tag_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int   FRAME_BITS = 7;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;

  // Even parity over {U,P,C,M}.
  function automatic logic tag_parity(input logic [2:0] upc, input logic marked);
    return ^{upc, marked};
  endfunction

endpackage

// File: rtl/upc_tag_tx_if.sv
// Record handshake and serial line between the checkout logic and the tag transmitter.
interface upc_tag_tx_if;
  logic [2:0] upc;
  logic       marked;
  logic       send;
  logic       ready;
  logic       tx_serial;
  logic       done;

  modport master (output upc, marked, send, input ready, tx_serial, done);
  modport slave  (input upc, marked, send, output ready, tx_serial, done);
endinterface

// File: rtl/upc_tag_tx_bit_timer.sv
// Bit-period timer: tick is high in the last cycle of every BIT_CYCLES-cycle bit slot.
module bit_timer #(
  parameter int BIT_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);
  localparam int             W    = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [W-1:0]   LAST = W'(BIT_CYCLES - 1);

  logic [W-1:0] count_reg;

  assign tick = (count_reg == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_reg <= '0;
    end else if (tick) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end
endmodule

// File: rtl/upc_tag_tx.sv
// Item-tag serial transmitter: frames {U,P,C,M} as start, data, even parity, stop
// on a single idle-high line, BIT_CYCLES clocks per bit.
module upc_tag_tx
  import upc_tag_pkg::*;
#(
  parameter int BIT_CYCLES = 4
) (
  input  logic            clk,
  input  logic            reset,
  upc_tag_tx_if.slave     bus
);
  tx_state_t                 state_reg;
  logic [FRAME_BITS-3:0]     shift_reg;   // {U,P,C,M,parity}, MSB goes out next
  logic [1:0]                idx_reg;
  logic                      tx_reg;
  logic                      ready_reg;
  logic                      done_reg;
  logic                      tick;

  assign bus.tx_serial = tx_reg;
  assign bus.ready     = ready_reg;
  assign bus.done      = done_reg;

  // The timer is held at zero while idle so the start bit gets a full slot.
  bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (state_reg == IDLE),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      idx_reg   <= '0;
      tx_reg    <= 1'b1;
      ready_reg <= 1'b1;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (ready_reg && bus.send) begin
            shift_reg <= {bus.upc, bus.marked, tag_parity(bus.upc, bus.marked)};
            idx_reg   <= '0;
            tx_reg    <= START_BIT;
            ready_reg <= 1'b0;
            state_reg <= START;
          end
        end
        START: begin
          if (tick) begin
            tx_reg    <= shift_reg[FRAME_BITS-3];
            shift_reg <= {shift_reg[FRAME_BITS-4:0], 1'b0};
            idx_reg   <= '0;
            state_reg <= DATA;
          end
        end
        DATA: begin
          // Each boundary shifts out the next bit; after M that is the parity bit.
          if (tick) begin
            tx_reg    <= shift_reg[FRAME_BITS-3];
            shift_reg <= {shift_reg[FRAME_BITS-4:0], 1'b0};
            idx_reg   <= idx_reg + 2'd1;
            if (idx_reg == 2'd3) begin
              state_reg <= PARITY;
            end
          end
        end
        PARITY: begin
          if (tick) begin
            tx_reg    <= STOP_BIT;
            state_reg <= STOP;
          end
        end
        STOP: begin
          if (tick) begin
            tx_reg    <= 1'b1;
            ready_reg <= 1'b1;
            done_reg  <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: begin
          tx_reg    <= 1'b1;
          ready_reg <= 1'b1;
          state_reg <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_upc_tag_tx.sv
// Directed bench for upc_tag_tx with BIT_CYCLES=4 and BIT_CYCLES=1 instances.
module tb_upc_tag_tx;
  logic clk;
  logic reset;
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   cyc          = 0;

  logic tx_log    [0:63];
  logic ready_log [0:63];
  logic done_log  [0:63];

  upc_tag_tx_if bus4 ();
  upc_tag_tx_if bus1 ();

  upc_tag_tx #(.BIT_CYCLES(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4.slave));
  upc_tag_tx #(.BIT_CYCLES(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  task automatic set_in(input int bc, input logic [2:0] u, input logic m, input logic s);
    if (bc == 1) begin
      bus1.upc = u; bus1.marked = m; bus1.send = s;
    end else begin
      bus4.upc = u; bus4.marked = m; bus4.send = s;
    end
  endtask

  // Presents a record, lets it be accepted, then logs cycles 1..7*bc+1.
  // mode 0: drop send after accept; 1: scramble inputs while busy; 2: hold send.
  task automatic run_frame(input int bc, input logic [2:0] u, input logic m,
                           input int mode, output int done_at);
    int n = 7 * bc + 1;
    set_in(bc, u, m, 1'b1);
    @(posedge clk); #1;
    if (mode == 0) set_in(bc, u, m, 1'b0);
    done_at = -1;
    for (int c = 1; c <= n; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      tx_log[c]    = (bc == 1) ? bus1.tx_serial : bus4.tx_serial;
      ready_log[c] = (bc == 1) ? bus1.ready     : bus4.ready;
      done_log[c]  = (bc == 1) ? bus1.done      : bus4.done;
      if (done_log[c] === 1'b1 && done_at < 0) done_at = cyc;
      if (mode == 1)
        set_in(bc, 3'($urandom_range(7)), 1'($urandom_range(1)), (c == n) ? 1'b0 : 1'(c % 2));
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    set_in(4, 3'b111, 1'b1, 1'b1);
    set_in(1, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if (bus4.ready !== 1'b1 || bus4.tx_serial !== 1'b1 || bus4.done !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_hold cyc%0d: got ready=%b tx=%b done=%b expected 1 1 0",
                 i, bus4.ready, bus4.tx_serial, bus4.done);
      end
    end
    reset = 1'b0;
    set_in(4, 3'b111, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if (bus4.ready !== 1'b1 || bus4.tx_serial !== 1'b1 || bus4.done !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_release cyc%0d: got ready=%b tx=%b done=%b expected 1 1 0",
                 i, bus4.ready, bus4.tx_serial, bus4.done);
      end
    end
  endtask

  task automatic test_single_frame;
    logic [6:0] exp = 7'b0110111;   // upc=110 marked=1 parity=1
    int d, rl, dc;
    run_frame(4, 3'b110, 1'b1, 0, d);
    for (int c = 1; c <= 28; c++) begin
      tests_run++;
      if (tx_log[c] !== exp[6 - (c - 1) / 4]) begin
        tests_failed++;
        $display("FAIL single_line cycle %0d: got %b expected %b", c, tx_log[c], exp[6 - (c - 1) / 4]);
      end
    end
    rl = 0; dc = 0;
    for (int c = 1; c <= 28; c++) begin
      if (ready_log[c] === 1'b0) rl++;
      if (done_log[c] !== 1'b0) dc++;
    end
    tests_run++;
    if (rl != 28 || ready_log[29] !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_ready: got low=%0d ready29=%b expected 28 1", rl, ready_log[29]);
    end
    tests_run++;
    if (dc != 0 || done_log[29] !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_done: got early=%0d done29=%b expected 0 1", dc, done_log[29]);
    end
  endtask

  task automatic test_input_stability;
    logic [6:0] exp = 7'b0101001;   // upc=101 marked=0 parity=0
    int d;
    run_frame(4, 3'b101, 1'b0, 1, d);
    for (int c = 1; c <= 28; c++) begin
      tests_run++;
      if (tx_log[c] !== exp[6 - (c - 1) / 4] || ready_log[c] !== 1'b0) begin
        tests_failed++;
        $display("FAIL stable_line cycle %0d: got tx=%b ready=%b expected tx=%b ready=0",
                 c, tx_log[c], ready_log[c], exp[6 - (c - 1) / 4]);
      end
    end
    @(posedge clk); #1;
    tests_run++;
    if (bus4.tx_serial !== 1'b1 || bus4.ready !== 1'b1 || bus4.done !== 1'b0) begin
      tests_failed++;
      $display("FAIL stable_no_second: got tx=%b ready=%b done=%b expected 1 1 0",
               bus4.tx_serial, bus4.ready, bus4.done);
    end
  endtask

  task automatic test_back_to_back;
    logic [6:0] exp = 7'b0101001;
    int d1, d2;
    for (int f = 0; f < 2; f++) begin
      run_frame(4, 3'b101, 1'b0, 2, d2);
      if (f == 0) d1 = d2;
      for (int c = 1; c <= 28; c++) begin
        tests_run++;
        if (tx_log[c] !== exp[6 - (c - 1) / 4]) begin
          tests_failed++;
          $display("FAIL b2b_line frame %0d cycle %0d: got %b expected %b",
                   f, c, tx_log[c], exp[6 - (c - 1) / 4]);
        end
      end
    end
    set_in(4, 3'b101, 1'b0, 1'b0);
    tests_run++;
    if (d1 < 0 || d2 - d1 != 29) begin
      tests_failed++;
      $display("FAIL b2b_done_spacing: got %0d (d1=%0d) expected 29", d2 - d1, d1);
    end
    @(posedge clk); #1;
    tests_run++;
    if (bus4.tx_serial !== 1'b1 || bus4.ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_idle_after: got tx=%b ready=%b expected 1 1", bus4.tx_serial, bus4.ready);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [6:0] exp = 7'b0011001;   // upc=011 marked=0 parity=0
    int d, bad;
    set_in(4, 3'b110, 1'b1, 1'b1);
    @(posedge clk); #1;
    set_in(4, 3'b110, 1'b1, 1'b0);
    repeat (13) begin @(posedge clk); #1; end
    tests_run++;   // cycle 14 carries bit C = 0
    if (bus4.tx_serial !== 1'b0 || bus4.ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_bitc: got tx=%b ready=%b expected 0 0", bus4.tx_serial, bus4.ready);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    tests_run++;
    if (bus4.tx_serial !== 1'b1 || bus4.ready !== 1'b1 || bus4.done !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_abort: got tx=%b ready=%b done=%b expected 1 1 0",
               bus4.tx_serial, bus4.ready, bus4.done);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus4.tx_serial !== 1'b1 || bus4.done !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL midreset_quiet: got %0d bad cycles expected 0", bad);
    end
    run_frame(4, 3'b011, 1'b0, 0, d);
    for (int c = 1; c <= 28; c++) begin
      tests_run++;
      if (tx_log[c] !== exp[6 - (c - 1) / 4]) begin
        tests_failed++;
        $display("FAIL midreset_refrm cycle %0d: got %b expected %b", c, tx_log[c], exp[6 - (c - 1) / 4]);
      end
    end
    tests_run++;
    if (done_log[29] !== 1'b1 || ready_log[29] !== 1'b1) begin
      tests_failed++;
      $display("FAIL midreset_done: got done=%b ready=%b expected 1 1", done_log[29], ready_log[29]);
    end
  endtask

  task automatic test_bit_cycles_one;
    logic [6:0] exp = 7'b0000001;
    int d, rl;
    run_frame(1, 3'b000, 1'b0, 0, d);
    rl = 0;
    for (int c = 1; c <= 7; c++) begin
      if (ready_log[c] === 1'b0) rl++;
      tests_run++;
      if (tx_log[c] !== exp[6 - (c - 1)] || done_log[c] !== 1'b0) begin
        tests_failed++;
        $display("FAIL bc1_line cycle %0d: got tx=%b done=%b expected tx=%b done=0",
                 c, tx_log[c], done_log[c], exp[6 - (c - 1)]);
      end
    end
    tests_run++;
    if (rl != 7 || done_log[8] !== 1'b1 || ready_log[8] !== 1'b1) begin
      tests_failed++;
      $display("FAIL bc1_done: got low=%0d done8=%b ready8=%b expected 7 1 1",
               rl, done_log[8], ready_log[8]);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_input_stability();
    test_back_to_back();
    test_reset_mid_frame();
    test_bit_cycles_one();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
